// File: rtl/fetch_pc_unit.sv
// Fetch PC generation and fetch/decode pipeline register with redirect bubbles.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC  = 32'h4000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  PCSel,
    input  logic [31:0] jal_target,
    input  logic [31:0] br_target,
    input  logic        stall,
    input  logic [31:0] imem_dout,
    input  logic        perf_clr,
    output logic [31:0] imem_addr,
    output logic [31:0] pc_f,
    output logic [31:0] pc_d,
    output logic [31:0] instr_d,
    output logic        valid_d,
    output logic [31:0] redirect_cnt,
    output logic [31:0] stall_cnt
);

    logic        redirect;
    logic [31:0] seq_pc;
    logic [31:0] next_pc;

    // PCSel == 11 is reserved and falls through to sequential fetch.
    assign redirect = (PCSel == 2'b01) || (PCSel == 2'b10);
    assign seq_pc   = pc_f + 32'd4;

    always_comb begin
        next_pc = seq_pc;
        case (PCSel)
            2'b01:   next_pc = jal_target;
            2'b10:   next_pc = br_target;
            default: next_pc = seq_pc;
        endcase
    end

    always_comb begin
        imem_addr = seq_pc;
        if (rst)
            imem_addr = RESET_PC;
        else if (redirect)
            imem_addr = next_pc;
        else if (stall)
            imem_addr = pc_f;
    end

    // Fetch stage: pc_f tags the word the synchronous memory returns next cycle.
    always_ff @(posedge clk) begin
        if (rst)
            pc_f <= RESET_PC;
        else
            pc_f <= imem_addr;
    end

    // Decode stage: a redirect squashes the wrong-path word into a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_d    <= RESET_PC;
            instr_d <= NOP_INSTR;
            valid_d <= 1'b0;
        end else if (redirect) begin
            pc_d    <= pc_f;
            instr_d <= NOP_INSTR;
            valid_d <= 1'b0;
        end else if (!stall) begin
            pc_d    <= pc_f;
            instr_d <= imem_dout;
            valid_d <= 1'b1;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst || perf_clr) begin
            redirect_cnt <= 32'd0;
            stall_cnt    <= 32'd0;
        end else if (redirect) begin
            redirect_cnt <= sat_inc(redirect_cnt);
        end else if (stall) begin
            stall_cnt    <= sat_inc(stall_cnt);
        end
    end
`else
    logic unused_perf_clr;

    assign unused_perf_clr = perf_clr;
    assign redirect_cnt    = 32'd0;
    assign stall_cnt       = 32'd0;
`endif

endmodule
